// File: rtl/calib_pkg.sv
// Shared types and helpers for the LED-chain calibration sequencer.
// Optional watchdog support is enabled by defining CALIB_SEQ_TIMEOUT_EN.
package calib_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        SET_BIT      = 3'd1,
        WAIT_FRAME   = 3'd2,
        SETTLE       = 3'd3,
        CAPTURE_REQ  = 3'd4,
        WAIT_CAPTURE = 3'd5,
        NEXT         = 3'd6,
        FINISH       = 3'd7
    } calib_seq_state_t;

    // Number of address bits needed to distinguish every LED on the chain.
    function automatic int addr_bits(input int num_leds);
        return $clog2(num_leds);
    endfunction

    // Counter width able to hold values 0..limit (at least one bit).
    function automatic int timer_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Reusable cycle timer: load clears the count, enable advances it, and
// expired is high on the LIMIT-th enabled cycle after a load (immediately
// when LIMIT is 0). The count saturates once expired.
module cycle_timer
    import calib_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int W = timer_width(LIMIT);
    localparam logic [W-1:0] LAST = (LIMIT < 1) ? {W{1'b0}} : W'(LIMIT - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign expired = (count_q >= LAST);

    // Next count: load wins, otherwise advance until the limit is reached.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = {W{1'b0}};
        end else if (enable && !expired) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/calib_sequencer.sv
// Calibration sequencer: walks the LED address bits one by one, waits for the
// display to show each bit, lets it settle, requests a camera capture and
// waits for completion. All outputs come straight from registers.
// Define CALIB_SEQ_TIMEOUT_EN to add a per-wait watchdog that raises the
// sticky timeout_err flag and abandons the sweep.
module calib_sequencer
    import calib_pkg::*;
#(
    parameter int NUM_LEDS       = 50,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 1 << 20,
    localparam int NB            = addr_bits(NUM_LEDS),
    localparam int BW            = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          frame_valid,
    input  logic          capture_ready,
    input  logic          capture_done,
    output logic [BW-1:0] bit_index,
    output logic          new_bit,
    output logic          capture_start,
    output logic          busy,
    output logic          done,
    output logic          timeout_err
);

    localparam logic [BW-1:0] LAST_BIT = BW'(NB - 1);

    calib_seq_state_t state_q;
    logic [BW-1:0]    bit_index_q;
    logic             new_bit_q;
    logic             capture_start_q;
    logic             busy_q;
    logic             done_q;
    // WAIT_FRAME ignores frame_valid until this is set after its first cycle.
    logic             wf_armed_q;

    logic             settle_load_s;
    logic             settle_en_s;
    logic             settle_expired_s;

    // The settle count restarts every time SETTLE is (re)entered.
    always_comb begin
        settle_en_s   = (state_q == SETTLE);
        settle_load_s = !settle_en_s;
    end

    cycle_timer #(
        .LIMIT (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (settle_load_s),
        .enable  (settle_en_s),
        .expired (settle_expired_s)
    );

`ifdef CALIB_SEQ_TIMEOUT_EN
    logic timeout_err_q;
    logic wd_active_s;
    logic wd_load_s;
    logic wd_expired_s;

    // Watchdog runs in the three wait states and is reloaded on every state
    // change; CAPTURE_REQ -> WAIT_CAPTURE is the only change between two
    // watched states, so the transfer cycle reloads explicitly.
    always_comb begin
        wd_active_s = (state_q == WAIT_FRAME) || (state_q == CAPTURE_REQ) ||
                      (state_q == WAIT_CAPTURE);
        if (!wd_active_s) begin
            wd_load_s = 1'b1;
        end else if ((state_q == CAPTURE_REQ) && capture_ready) begin
            wd_load_s = 1'b1;
        end else begin
            wd_load_s = 1'b0;
        end
    end

    cycle_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wd_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (wd_load_s),
        .enable  (wd_active_s),
        .expired (wd_expired_s)
    );

    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYCLES > 0);
    assign timeout_err      = 1'b0;
`endif

    // Sequencer FSM; priority is reset, then abort, then watchdog, then flow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            bit_index_q     <= {BW{1'b0}};
            new_bit_q       <= 1'b0;
            capture_start_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            wf_armed_q      <= 1'b0;
`ifdef CALIB_SEQ_TIMEOUT_EN
            timeout_err_q   <= 1'b0;
`endif
        end else if (abort && (state_q != IDLE)) begin
            state_q         <= IDLE;
            new_bit_q       <= 1'b0;
            capture_start_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            wf_armed_q      <= 1'b0;
`ifdef CALIB_SEQ_TIMEOUT_EN
        end else if (wd_active_s && wd_expired_s) begin
            state_q         <= IDLE;
            new_bit_q       <= 1'b0;
            capture_start_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            wf_armed_q      <= 1'b0;
            timeout_err_q   <= 1'b1;
`endif
        end else begin
            new_bit_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q       <= SET_BIT;
                        bit_index_q   <= {BW{1'b0}};
                        new_bit_q     <= 1'b1;
                        busy_q        <= 1'b1;
`ifdef CALIB_SEQ_TIMEOUT_EN
                        timeout_err_q <= 1'b0;
`endif
                    end
                end
                SET_BIT: begin
                    state_q    <= WAIT_FRAME;
                    wf_armed_q <= 1'b0;
                end
                WAIT_FRAME: begin
                    if (wf_armed_q && frame_valid) begin
                        state_q    <= SETTLE;
                        wf_armed_q <= 1'b0;
                    end else begin
                        wf_armed_q <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (!frame_valid) begin
                        state_q <= WAIT_FRAME;
                    end else if (settle_expired_s) begin
                        state_q         <= CAPTURE_REQ;
                        capture_start_q <= 1'b1;
                    end
                end
                CAPTURE_REQ: begin
                    if (capture_ready) begin
                        state_q         <= WAIT_CAPTURE;
                        capture_start_q <= 1'b0;
                    end
                end
                WAIT_CAPTURE: begin
                    if (capture_done) begin
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    if (bit_index_q == LAST_BIT) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                    end else begin
                        bit_index_q <= bit_index_q + BW'(1);
                        state_q     <= SET_BIT;
                        new_bit_q   <= 1'b1;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q         <= IDLE;
                    capture_start_q <= 1'b0;
                    busy_q          <= 1'b0;
                    wf_armed_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bit_index     = bit_index_q;
    assign new_bit       = new_bit_q;
    assign capture_start = capture_start_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_calib_sequencer.sv
// Scoreboard bench for calib_sequencer (NUM_LEDS=50, SETTLE_CYCLES=4,
// TIMEOUT_CYCLES=16). One negedge-synchronous task samples outputs, checks
// them against queued expectations and drives the responding environment.
module tb_calib_sequencer;

    localparam int NBITS = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       frame_valid = 1'b0;
    logic       capture_ready = 1'b1;
    logic       capture_done = 1'b0;
    logic [2:0] bit_index;
    logic       new_bit;
    logic       capture_start;
    logic       busy;
    logic       done;
    logic       timeout_err;

    calib_sequencer #(
        .NUM_LEDS       (50),
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .frame_valid   (frame_valid),
        .capture_ready (capture_ready),
        .capture_done  (capture_done),
        .bit_index     (bit_index),
        .new_bit       (new_bit),
        .capture_start (capture_start),
        .busy          (busy),
        .done          (done),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bit_idx;
        int lat;
        int len;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    int n_checks = 0;
    int n_fail   = 0;

    int glitch_bit = -1;
    int bp_bit     = -1;
    int abort_bit  = -1;
    int rst_bit    = -1;
    bit fv_block   = 1'b0;
    bit rst_start  = 1'b0;
    bit start_pend = 1'b0;
    bit abort_pend = 1'b0;
    int rst_cyc    = 3;

    int nb_age   = 1000;
    int cs_age   = 0;
    int cs_len   = 0;
    int tr_age   = 1000;
    int done_cnt = 0;
    int xfer_cnt = 0;
    bit abort_seen = 1'b0;
    bit rst_seen   = 1'b0;
    bit prev_nb    = 1'b0;
    bit prev_cs    = 1'b0;
    bit prev_done  = 1'b0;
    bit prev_abort = 1'b0;
    bit prev_rst   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void push_sweep(input int nbits, input int g_bit, input int b_bit);
        for (int i = 0; i < nbits; i++) begin
            exp_t e;
            e.bit_idx = i;
            e.lat     = (i == g_bit) ? 12 : 8;
            e.len     = (i == b_bit) ? 11 : 1;
            exp_q.push_back(e);
        end
    endfunction

    task automatic tick();
        int bi;
        @(negedge clk);
        bi = int'(bit_index);
        if (prev_rst) begin
            check_eq("rst_bit_index", bit_index, 0);
            check_eq("rst_new_bit", new_bit, 0);
            check_eq("rst_capture_start", capture_start, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_done", done, 0);
            check_eq("rst_timeout_err", timeout_err, 0);
        end else if (prev_abort) begin
            check_eq("abort_busy", busy, 0);
            check_eq("abort_capture_start", capture_start, 0);
            check_eq("abort_new_bit", new_bit, 0);
            check_eq("abort_done", done, 0);
        end
        if (prev_nb) check_eq("new_bit_width", new_bit, 0);
        if (prev_done) begin
            check_eq("busy_after_done", busy, 0);
            check_eq("done_width", done, 0);
        end
        if (new_bit) begin
            check_eq("terr_clear_on_start", timeout_err, 0);
            check_eq("new_bit_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                check_eq("bit_index", bit_index, cur.bit_idx);
            end
            nb_age = 0;
        end else if (nb_age < 1000) begin
            nb_age++;
        end
        if (capture_start && !prev_cs) begin
            check_eq("cs_latency", nb_age, cur.lat);
            cs_age = 0;
            cs_len = 1;
        end else if (capture_start) begin
            cs_age++;
            cs_len++;
        end
        if (!capture_start && prev_cs) check_eq("cs_length", cs_len, cur.len);
        if (done) begin
            done_cnt++;
            check_eq("busy_during_done", busy, 1);
        end

        // Environment response for this cycle.
        if (tr_age < 1000) tr_age++;
        frame_valid   = !fv_block && (nb_age >= 3) && !((bi == glitch_bit) && (nb_age == 5));
        capture_ready = !(capture_start && (bi == bp_bit) && (cs_age < 10));
        capture_done  = (tr_age == 5);
        if ((rst_cyc == 0) && busy && (bi == rst_bit) && (nb_age == 5)) begin
            rst_cyc  = 2;
            rst_seen = 1'b1;
            rst_bit  = -1;
        end
        rst   = (rst_cyc > 0);
        start = start_pend || ((rst_cyc == 1) && rst_start);
        abort = abort_pend || (capture_done && busy && (bi == abort_bit)) ||
                ((rst_cyc == 1) && rst_start);
        if (abort && !rst) abort_seen = 1'b1;
        if (rst_cyc > 0) rst_cyc--;
        start_pend = 1'b0;
        abort_pend = 1'b0;
        if (capture_start && capture_ready) begin
            xfer_cnt++;
            tr_age = 0;
        end
        prev_nb    = new_bit;
        prev_cs    = capture_start;
        prev_done  = done;
        prev_abort = abort;
        prev_rst   = rst;
    endtask

    task automatic run_full_sweep(input string name, input int g_bit, input int b_bit);
        int d0;
        int x0;
        int n;
        d0 = done_cnt;
        x0 = xfer_cnt;
        glitch_bit = g_bit;
        bp_bit     = b_bit;
        push_sweep(NBITS, g_bit, b_bit);
        start_pend = 1'b1;
        n = 0;
        while ((done_cnt == d0) && (n < 400)) begin
            tick();
            n++;
        end
        tick();
        tick();
        check_eq({name, "_done_count"}, done_cnt - d0, 1);
        check_eq({name, "_transfers"}, xfer_cnt - x0, NBITS);
        check_eq({name, "_queue_left"}, exp_q.size(), 0);
        check_eq({name, "_idle"}, busy, 0);
        exp_q.delete();
        glitch_bit = -1;
        bp_bit     = -1;
    endtask

    initial begin
        int d0;
        int x0;
        int n;

        // Power-on reset held for three cycles.
        repeat (6) tick();
        check_eq("idle_after_reset", busy, 0);

        run_full_sweep("nominal", -1, -1);
        run_full_sweep("glitch_bp", 1, 3);

        // Abort coinciding with capture_done on bit 3.
        d0 = done_cnt;
        x0 = xfer_cnt;
        abort_bit  = 3;
        abort_seen = 1'b0;
        push_sweep(4, -1, -1);
        start_pend = 1'b1;
        n = 0;
        while (!abort_seen && (n < 400)) begin
            tick();
            n++;
        end
        repeat (20) tick();
        check_eq("abort_reached", abort_seen, 1);
        check_eq("abort_no_done", done_cnt - d0, 0);
        check_eq("abort_transfers", xfer_cnt - x0, 4);
        check_eq("abort_queue_left", exp_q.size(), 0);
        check_eq("abort_idle", busy, 0);
        exp_q.delete();
        abort_bit = -1;

        run_full_sweep("restart", -1, -1);

        // Reset in SETTLE of bit 2, with start/abort during the last reset cycle.
        d0 = done_cnt;
        x0 = xfer_cnt;
        rst_bit   = 2;
        rst_start = 1'b1;
        rst_seen  = 1'b0;
        push_sweep(3, -1, -1);
        start_pend = 1'b1;
        n = 0;
        while (!(rst_seen && (rst_cyc == 0)) && (n < 400)) begin
            tick();
            n++;
        end
        repeat (10) tick();
        check_eq("reset_reached", rst_seen, 1);
        check_eq("reset_no_done", done_cnt - d0, 0);
        check_eq("reset_transfers", xfer_cnt - x0, 2);
        check_eq("reset_queue_left", exp_q.size(), 0);
        check_eq("reset_idle", busy, 0);
        exp_q.delete();
        rst_start = 1'b0;
        rst_bit   = -1;

        // Display never becomes valid.
        d0 = done_cnt;
        fv_block = 1'b1;
        push_sweep(1, -1, -1);
        start_pend = 1'b1;
        tick();
        tick();
`ifdef CALIB_SEQ_TIMEOUT_EN
        n = 0;
        while (busy && (n < 100)) begin
            tick();
            n++;
        end
        check_eq("wd_latency", nb_age, 17);
        check_eq("wd_timeout_err", timeout_err, 1);
        check_eq("wd_busy", busy, 0);
        check_eq("wd_no_done", done_cnt - d0, 0);
`else
        repeat (40) tick();
        check_eq("nowd_still_busy", busy, 1);
        check_eq("nowd_timeout_err", timeout_err, 0);
`endif
        abort_pend = 1'b1;
        tick();
        tick();
        check_eq("stall_idle", busy, 0);
        exp_q.delete();
        fv_block = 1'b0;

        run_full_sweep("after_stall", -1, -1);
        check_eq("final_timeout_err", timeout_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
